// File: rtl/div_unit_pkg.sv
// Shared encodings for the iterative divider: FSM states and handshake levels.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic RST_ENABLE           = 1'b1;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider, signed or unsigned, one quotient bit per cycle.
//
// state      | meaning
// -----------+------------------------------------------------------------
// DIV_FREE   | idle, waiting for start_i (annul_i blocks acceptance)
// DIV_BYZERO | divisor was zero; result forced to 0
// DIV_ON     | shift-subtract iterations, cnt counts steps up to DATA_W
// DIV_END    | result_o/ready_o held until start_i drops
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  div_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*DATA_W:0]      part_q, part_d;
  logic [DATA_W-1:0]      divisor_q, divisor_d;
  logic                   neg_quo_q, neg_quo_d;
  logic                   neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0]    result_q, result_d;
  logic                   ready_q, ready_d;

  logic [DATA_W-1:0]      mag1, mag2;
  logic [DATA_W+1:0]      diff;
  logic [DATA_W-1:0]      quo_raw, rem_raw, quo_fix, rem_fix;

  // Operand magnitudes, step subtraction and final sign correction.
  always_comb begin
    mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    // part_q[2W] is always 0 between steps; it acts as the extra guard bit so the
    // shifted remainder (up to 2*divisor-1) never overflows for large unsigned divisors.
    diff    = part_q[2*DATA_W:DATA_W-1] - {2'b00, divisor_q};
    quo_raw = part_q[DATA_W-1:0];
    rem_raw = part_q[2*DATA_W-1:DATA_W];
    quo_fix = neg_quo_q ? (~quo_raw + 1'b1) : quo_raw;
    rem_fix = neg_rem_q ? (~rem_raw + 1'b1) : rem_raw;
  end

  // Next-state and datapath updates for the divider FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    part_d    = part_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    unique case (state_q)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d   = DIV_ON;
            cnt_d     = '0;
            part_d    = {{(DATA_W+1){1'b0}}, mag1};
            divisor_d = mag2;
            neg_quo_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_d = signed_div_i && opdata1_i[DATA_W-1];
          end
        end
      end
      DIV_BYZERO: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        state_d  = annul_i ? DIV_FREE : DIV_END;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DIV_END;
          result_d = {rem_fix, quo_fix};
          ready_d  = DIV_RESULT_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (diff[DATA_W+1])
            part_d = {part_q[2*DATA_W-1:0], 1'b0};
          else
            part_d = {diff[DATA_W:0], part_q[DATA_W-2:0], 1'b1};
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else begin
          // The zero-divisor path arrives here with ready low and raises it now.
          ready_d = DIV_RESULT_READY;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      part_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      part_q    <= part_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues expected results, a monitor checks them.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result_o;
  logic        ready_o;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        mon_prev;
  logic [63:0] mon_held;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: on each rising ready_o pop one expectation; while held, result must not move.
  initial begin
    exp_t e;
    mon_prev = 1'b0;
    mon_held = '0;
    forever begin
      @(negedge clk);
      if (ready_o === 1'b1) begin
        if (!mon_prev) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: result %h with no request outstanding", result_o);
          end else begin
            e = sb_q.pop_front();
            chk("result", result_o, e.res);
            chk("latency", 64'(cyc), 64'(e.cyc));
            mon_held = e.res;
          end
        end else begin
          chk("hold", result_o, mon_held);
        end
      end
      mon_prev = (ready_o === 1'b1);
    end
  end

  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit zero, input bit drop_start,
                        input bit scramble);
    exp_t e;
    int   k;
    @(negedge clk);
    signed_div_i = sgn;
    op1   = a;
    op2   = b;
    start = 1'b1;
    e.res = exp;
    e.cyc = cyc + 1 + (zero ? 2 : 33);
    sb_q.push_back(e);
    @(negedge clk);
    if (scramble) begin
      op1 = ~a;
      op2 = b + 32'd5;
      signed_div_i = ~sgn;
    end
    if (drop_start) start = 1'b0;
    k = 0;
    while (ready_o !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (ready_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout: ready_o not seen within 60 cycles for %h / %h", a, b);
      sb_q.delete();
    end
    if (!drop_start) begin
      annul = 1'b1;
      repeat (3) @(negedge clk);
      annul = 1'b0;
      start = 1'b0;
    end
    @(negedge clk);
    chk("release_ready", {63'd0, ready_o}, 64'd0);
    chk("release_result", result_o, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    signed_div_i = 1'b0;
    op1 = '0;
    op2 = '0;
    start = 1'b0;
    annul = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst = 1'b0;

    do_div(1'b1, 32'd100,        32'd7,        {32'd2,          32'd14},          1'b0, 1'b0, 1'b0);
    do_div(1'b1, 32'hFFFFFF9C,   32'd7,        {32'hFFFFFFFE,   32'hFFFFFFF2},    1'b0, 1'b0, 1'b0);
    do_div(1'b1, 32'd100,        32'hFFFFFFF9, {32'd2,          32'hFFFFFFF2},    1'b0, 1'b0, 1'b0);
    do_div(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE,   32'd14},          1'b0, 1'b0, 1'b0);
    do_div(1'b0, 32'hFFFFFFFF,   32'd2,        {32'd1,          32'h7FFFFFFF},    1'b0, 1'b0, 1'b0);
    do_div(1'b0, 32'h80000000,   32'h80000001, {32'h80000000,   32'd0},           1'b0, 1'b0, 1'b0);
    do_div(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE, {32'd1,          32'd1},           1'b0, 1'b0, 1'b0);
    do_div(1'b1, 32'h80000000,   32'hFFFFFFFF, {32'd0,          32'h80000000},    1'b0, 1'b0, 1'b0);
    do_div(1'b1, 32'h00001234,   32'd0,        64'd0,                             1'b1, 1'b0, 1'b0);
    do_div(1'b0, 32'd1000,       32'd10,       {32'd0,          32'd100},         1'b0, 1'b1, 1'b1);
    do_div(1'b1, 32'd7,          32'd100,      {32'd7,          32'd0},           1'b0, 1'b0, 1'b0);

    // Annul at cycle 10 of ON: no result, then a fresh 9 / 3.
    @(negedge clk);
    signed_div_i = 1'b0;
    op1 = 32'd1000;
    op2 = 32'd3;
    start = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    chk("annul_ready", {63'd0, ready_o}, 64'd0);
    chk("annul_result", result_o, 64'd0);
    repeat (40) @(negedge clk);
    chk("annul_quiet", {63'd0, ready_o}, 64'd0);
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 1'b0, 1'b0);

    // Annul held in FREE blocks acceptance even with start high.
    @(negedge clk);
    op1 = 32'd50;
    op2 = 32'd5;
    start = 1'b1;
    annul = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    annul = 1'b0;
    repeat (40) @(negedge clk);
    chk("free_annul_quiet", {63'd0, ready_o}, 64'd0);

    // Reset at cycle 20 of ON discards the division.
    op1 = 32'd12345;
    op2 = 32'd11;
    start = 1'b1;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {63'd0, ready_o}, 64'd0);
    chk("midrst_result", result_o, 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_quiet", {63'd0, ready_o}, 64'd0);

    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 1'b0, 1'b0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter DATA_W, default 32, is the operand width; all widths below derive from it.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high (`RstEnable` = 1).
REQ-004 signed_div_i  input  1  1 = two's-complement division, 0 = unsigned.
REQ-005 opdata1_i  input  DATA_W  dividend.
REQ-006 opdata2_i  input  DATA_W  divisor.
REQ-007 start_i  input  1  request (`DivStart`) / release (`DivStop`) from Ex.
REQ-008 annul_i  input  1  cancel an in-flight division.
REQ-009 result_o  output  2*DATA_W  {remainder[2*DATA_W-1:DATA_W], quotient[DATA_W-1:0]}.
REQ-010 ready_o  output  1  `DivResultReady` when result_o is valid, else `DivResultNotReady`.

Function
REQ-011 The block SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-012 FREE, start_i=1, annul_i=0: divisor == 0 -> BYZERO; else -> ON, with cnt=0 and the magnitudes latched.
REQ-013 Magnitudes when signed_div_i=1: negate an operand if its MSB is set. When 0: use the operands unchanged.
REQ-014 Operands SHALL be captured only on the acceptance edge. Input changes afterwards have no effect.
REQ-015 ON: each cycle is one restoring shift-subtract step on a 2*DATA_W+1-bit partial remainder; cnt increments.
REQ-016 ON, cnt == DATA_W: -> END.
  - Quotient is negated iff signed and the operand MSBs differ.
  - Remainder is negated iff signed and the dividend MSB is set.
  - The corrected values are registered into result_o and ready_o=1.
REQ-017 Latency: for acceptance edge N, ready_o SHALL be high after edge N+DATA_W+1 (N+33 at 32 bits).
REQ-018 BYZERO: next edge -> END with result_o = 0 and ready_o=1. ready_o is therefore high after edge N+2.
REQ-019 END: hold result_o and ready_o while start_i=1. Once start_i=0: -> FREE, result_o=0, ready_o=0.
REQ-020 annul_i=1 in ON or BYZERO: -> FREE on the next edge, ready_o stays 0, result_o=0, no result produced.
REQ-021 annul_i=1 in FREE SHALL block acceptance even if start_i=1.
REQ-022 annul_i in END SHALL be ignored; only start_i=0 releases END.
REQ-023 start_i dropping during ON SHALL NOT abort the division; annul_i is the only abort.
REQ-024 Signed -2^31 / -1 SHALL give quotient 0x8000_0000 and remainder 0 (wraparound, no trap).
REQ-025 Unsigned operands with MSB set SHALL be treated as large positive values.
REQ-026 Back-to-back use: a new start_i is accepted only from FREE, so one idle cycle separates results.

Reset
REQ-027 rst=1 at an edge SHALL force state=FREE, cnt=0, result_o=0, ready_o=0, regardless of state, start_i or annul_i.
REQ-028 rst asserted mid-division SHALL discard the operation. No ready_o pulse follows reset release.

Structure
REQ-029 State encodings DivFree/DivByZero/DivOn/DivEnd SHALL reside in Defines.v. DivStart/DivStop and DivResultReady/DivResultNotReady SHALL also reside there.
REQ-030 The block SHALL use `DoubleRegBus` for result_o in the shared Defines.v.
REQ-031 The block is a single module with no sub-module. The step datapath is a single subtract-and-compare inside the FSM.
REQ-032 Ex drives start_i/annul_i/operands, holds stall while ready_o=0, and deasserts start_i after capturing the result.

Verification
REQ-033 Signed: 100 / 7 -> after 33 edges ready_o=1, quotient 14, remainder 2. Holds until start_i=0, then FREE.
REQ-034 Signed: -100 / 7 -> quotient 0xFFFF_FFF2 (-14), remainder 0xFFFF_FFFE (-2). Unsigned 0xFFFF_FFFF / 2 -> quotient 0x7FFF_FFFF, remainder 1.
REQ-035 Divisor 0 with any dividend -> ready_o=1 two edges after acceptance, result_o = 0.
REQ-036 Signed 0x8000_0000 / 0xFFFF_FFFF -> quotient 0x8000_0000, remainder 0.
REQ-037 annul_i pulsed at cycle 10 of ON -> FREE next edge, ready_o never rises. A new start of 9 / 3 then yields quotient 3, remainder 0.
REQ-038 rst pulsed at cycle 20 of ON -> all outputs 0, state FREE. Operands changed after acceptance -> result reflects the captured values.
